// File: rtl/otter_pkg.sv
// -----------------------------------------------------------------------------
// otter_pkg
// Shared definitions for the OTTER branch logic:
//   opcode_t   - RV32I major opcodes (IR[6:0])
//   pcsource_t - PC mux select values driven toward the fetch stage
//   F3_*       - branch FUNC3 encodings
//   Helpers:   branch_f3_legal(), ctr_next() (2-bit saturating counter step)
// -----------------------------------------------------------------------------
package otter_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    PC_PLUS4   = 3'b000,
    PC_JALR    = 3'b001,
    PC_BRANCH  = 3'b010,
    PC_JAL     = 3'b011,
    PC_RECOVER = 3'b100
  } pcsource_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // FUNC3 010/011 have no branch meaning.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  // One training step of a 2-bit saturating counter.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    r = ctr;
    if (taken) begin
      if (ctr != 2'b11) r = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) r = ctr - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// -----------------------------------------------------------------------------
// bht_2bit
// Table of 2-bit saturating counters, untagged.
//   clk, rst_n  - clock, synchronous active-low reset (all entries -> INIT)
//   rd_idx      - combinational read index
//   rd_ctr      - counter value at rd_idx (pre-edge value, no write bypass)
//   upd_en      - train the entry at upd_idx at this edge
//   upd_idx     - entry to train
//   upd_taken   - 1: increment (sat 11), 0: decrement (sat 00)
// -----------------------------------------------------------------------------
module bht_2bit
  import otter_pkg::*;
#(
  parameter int         ENTRIES = 64,
  parameter logic [1:0] INIT    = 2'b01,
  localparam int        IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d [ENTRIES];

  // Reads see the registered table only, so a same-cycle update is invisible.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ctr_d[i] = ctr_q[i];
    end
    if (upd_en) begin
      ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (!rst_n) ctr_q[i] <= INIT;
      else        ctr_q[i] <= ctr_d[i];
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Branch prediction (decode) and branch/jump resolution (EX) for the pipelined
// OTTER, with BHT training and branch/mispredict statistics.
//   CLK, RST_N        - clock, synchronous active-low reset
//   DEC_VALID/PC/OPCODE -> PRED_TAKEN (combinational prediction)
//   EX_VALID, EX_STALL, EX_PC, EX_OPCODE, EX_FUNC3, EX_RS1, EX_RS2,
//   EX_PRED_TAKEN     - EX-stage instruction and its carried prediction
//   PCSOURCE, FLUSH   - registered redirect, one cycle after resolve
//   BR_COUNT          - legal conditional branches resolved (wraps)
//   MISPRED_COUNT     - mispredicted conditional branches (wraps)
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import otter_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            DEC_VALID,
  input  logic [XLEN-1:0] DEC_PC,
  input  logic [6:0]      DEC_OPCODE,
  output logic            PRED_TAKEN,
  input  logic            EX_VALID,
  input  logic            EX_STALL,
  input  logic [XLEN-1:0] EX_PC,
  input  logic [6:0]      EX_OPCODE,
  input  logic [2:0]      EX_FUNC3,
  input  logic [XLEN-1:0] EX_RS1,
  input  logic [XLEN-1:0] EX_RS2,
  input  logic            EX_PRED_TAKEN,
  output logic [2:0]      PCSOURCE,
  output logic            FLUSH,
  output logic [31:0]     BR_COUNT,
  output logic [31:0]     MISPRED_COUNT
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       dec_ctr;

  pcsource_t   pcsource_q, pcsource_d;
  logic        flush_q, flush_d;
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  logic res;
  logic is_branch;
  logic f3_legal;
  logic eq, lt, ltu;
  logic cond_taken;
  logic bht_upd_en;

  // Word-aligned index; PC bits outside the index deliberately alias.
  assign dec_idx = DEC_PC[IDX_W+1:2];
  assign ex_idx  = EX_PC[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{DEC_PC[XLEN-1:IDX_W+2], DEC_PC[1:0],
                            EX_PC[XLEN-1:IDX_W+2], EX_PC[1:0]};

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .INIT    (CTR_INIT)
  ) u_bht (
    .clk       (CLK),
    .rst_n     (RST_N),
    .rd_idx    (dec_idx),
    .rd_ctr    (dec_ctr),
    .upd_en    (bht_upd_en),
    .upd_idx   (ex_idx),
    .upd_taken (cond_taken)
  );

  assign PRED_TAKEN = DEC_VALID && (DEC_OPCODE == BRANCH) && dec_ctr[1];

  // The EX slot during a FLUSH cycle holds a wrong-path instruction.
  assign res       = EX_VALID && !EX_STALL && !flush_q;
  assign is_branch = (EX_OPCODE == BRANCH);
  assign f3_legal  = branch_f3_legal(EX_FUNC3);

  assign eq  = (EX_RS1 == EX_RS2);
  assign lt  = ($signed(EX_RS1) < $signed(EX_RS2));
  assign ltu = (EX_RS1 < EX_RS2);

  always_comb begin
    cond_taken = 1'b0;
    case (EX_FUNC3)
      F3_BEQ:  cond_taken = eq;
      F3_BNE:  cond_taken = !eq;
      F3_BLT:  cond_taken = lt;
      F3_BGE:  cond_taken = !lt;
      F3_BLTU: cond_taken = ltu;
      F3_BGEU: cond_taken = !ltu;
      default: cond_taken = 1'b0;
    endcase
  end

  assign bht_upd_en = RST_N && res && is_branch && f3_legal;

  always_comb begin
    pcsource_d      = PC_PLUS4;
    flush_d         = 1'b0;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (res) begin
      if (EX_OPCODE == JAL) begin
        pcsource_d = PC_JAL;
        flush_d    = 1'b1;
      end else if (EX_OPCODE == JALR) begin
        pcsource_d = PC_JALR;
        flush_d    = 1'b1;
      end else if (is_branch) begin
        // Illegal FUNC3 falls out as not-taken via cond_taken=0.
        if (cond_taken && !EX_PRED_TAKEN) begin
          pcsource_d = PC_BRANCH;
          flush_d    = 1'b1;
        end else if (!cond_taken && EX_PRED_TAKEN) begin
          pcsource_d = PC_RECOVER;
          flush_d    = 1'b1;
        end
        if (f3_legal) begin
          br_count_d = br_count_q + 32'd1;
          if (cond_taken != EX_PRED_TAKEN) begin
            mispred_count_d = mispred_count_q + 32'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pcsource_q      <= PC_PLUS4;
      flush_q         <= 1'b0;
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      pcsource_q      <= pcsource_d;
      flush_q         <= flush_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign PCSOURCE      = pcsource_q;
  assign FLUSH         = flush_q;
  assign BR_COUNT      = br_count_q;
  assign MISPRED_COUNT = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed steps from the test plan followed by randomized transactions, all
// checked against a behavioural model of the predictor and resolver.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam int         N_ENT    = 64;
  localparam int         INIT_CTR = 1;

  logic        CLK;
  logic        RST_N;
  logic        DEC_VALID;
  logic [31:0] DEC_PC;
  logic [6:0]  DEC_OPCODE;
  logic        PRED_TAKEN;
  logic        EX_VALID;
  logic        EX_STALL;
  logic [31:0] EX_PC;
  logic [6:0]  EX_OPCODE;
  logic [2:0]  EX_FUNC3;
  logic [31:0] EX_RS1;
  logic [31:0] EX_RS2;
  logic        EX_PRED_TAKEN;
  logic [2:0]  PCSOURCE;
  logic        FLUSH;
  logic [31:0] BR_COUNT;
  logic [31:0] MISPRED_COUNT;

  branch_resolve_unit dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .DEC_VALID     (DEC_VALID),
    .DEC_PC        (DEC_PC),
    .DEC_OPCODE    (DEC_OPCODE),
    .PRED_TAKEN    (PRED_TAKEN),
    .EX_VALID      (EX_VALID),
    .EX_STALL      (EX_STALL),
    .EX_PC         (EX_PC),
    .EX_OPCODE     (EX_OPCODE),
    .EX_FUNC3      (EX_FUNC3),
    .EX_RS1        (EX_RS1),
    .EX_RS2        (EX_RS2),
    .EX_PRED_TAKEN (EX_PRED_TAKEN),
    .PCSOURCE      (PCSOURCE),
    .FLUSH         (FLUSH),
    .BR_COUNT      (BR_COUNT),
    .MISPRED_COUNT (MISPRED_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  int          m_bht [N_ENT];
  int          m_pcsrc;
  bit          m_flush;
  int unsigned m_br;
  int unsigned m_mis;

  int n_vec;
  int n_err;
  int n_txn;

  function automatic int bht_index(input logic [31:0] pc);
    return int'((pc / 4) % N_ENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_ENT; i++) m_bht[i] = INIT_CTR;
    m_pcsrc = 0;
    m_flush = 0;
    m_br    = 0;
    m_mis   = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check the combinational prediction, clock,
  // advance the model, check the registered outputs.
  task automatic step(input bit rst_n, input bit dv, input logic [31:0] dpc,
                      input logic [6:0] dop, input bit ev, input bit es,
                      input logic [31:0] epc, input logic [6:0] eop,
                      input logic [2:0] ef3, input logic [31:0] rs1,
                      input logic [31:0] rs2, input bit ep);
    bit res, legal, tk;
    int npc;
    bit nfl;
    int ix;
    RST_N = rst_n; DEC_VALID = dv; DEC_PC = dpc; DEC_OPCODE = dop;
    EX_VALID = ev; EX_STALL = es; EX_PC = epc; EX_OPCODE = eop;
    EX_FUNC3 = ef3; EX_RS1 = rs1; EX_RS2 = rs2; EX_PRED_TAKEN = ep;
    #1;
    check("pred_taken", {31'd0, PRED_TAKEN},
          {31'd0, (dv && dop == T_BRANCH && m_bht[bht_index(dpc)] >= 2)});
    @(posedge CLK);
    if (!rst_n) begin
      model_reset();
    end else begin
      res = ev && !es && !m_flush;
      npc = 0;
      nfl = 0;
      if (res) begin
        if (eop == T_JAL) begin
          npc = 3; nfl = 1;
        end else if (eop == T_JALR) begin
          npc = 1; nfl = 1;
        end else if (eop == T_BRANCH) begin
          legal = !(ef3 == 3'd2 || ef3 == 3'd3);
          case (ef3)
            3'd0:    tk = (rs1 == rs2);
            3'd1:    tk = (rs1 != rs2);
            3'd4:    tk = ($signed(rs1) < $signed(rs2));
            3'd5:    tk = ($signed(rs1) >= $signed(rs2));
            3'd6:    tk = (rs1 < rs2);
            3'd7:    tk = (rs1 >= rs2);
            default: tk = 0;
          endcase
          if (tk && !ep) begin
            npc = 2; nfl = 1;
          end else if (!tk && ep) begin
            npc = 4; nfl = 1;
          end
          if (legal) begin
            m_br++;
            if (tk != ep) m_mis++;
            ix = bht_index(epc);
            if (tk) m_bht[ix] = (m_bht[ix] == 3) ? 3 : m_bht[ix] + 1;
            else    m_bht[ix] = (m_bht[ix] == 0) ? 0 : m_bht[ix] - 1;
          end
        end
      end
      m_pcsrc = npc;
      m_flush = nfl;
    end
    #1;
    check("pcsource", {29'd0, PCSOURCE}, m_pcsrc);
    check("flush", {31'd0, FLUSH}, {31'd0, m_flush});
    check("br_count", BR_COUNT, m_br);
    check("mispred_count", MISPRED_COUNT, m_mis);
    n_txn++;
    $display("txn %0d: rst_n=%0b ex_v=%0b st=%0b op=%02h f3=%0d pc=%08h pred=%0b -> pcsrc=%0d flush=%0b br=%0d mis=%0d",
             n_txn, rst_n, ev, es, eop, ef3, epc, ep, PCSOURCE, FLUSH, BR_COUNT, MISPRED_COUNT);
  endtask

  // EX-idle cycle with decode looking at a given PC
  task automatic idle(input logic [31:0] dpc);
    step(1, 1, dpc, T_BRANCH, 0, 0, 32'h0, T_OP, 3'd0, 32'd0, 32'd0, 0);
  endtask

  initial begin
    logic [6:0]  ops [9];
    logic [31:0] rpc, a, b;
    n_vec = 0; n_err = 0; n_txn = 0;
    ops = '{T_BRANCH, T_BRANCH, T_BRANCH, T_BRANCH, T_BRANCH, T_JAL, T_JALR, T_OP, T_LOAD};

    // Hold reset for two cycles before any checking
    RST_N = 0; DEC_VALID = 0; DEC_PC = 0; DEC_OPCODE = 0;
    EX_VALID = 0; EX_STALL = 0; EX_PC = 0; EX_OPCODE = 0;
    EX_FUNC3 = 0; EX_RS1 = 0; EX_RS2 = 0; EX_PRED_TAKEN = 0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();

    // Post-reset state, BRANCH in decode at 0x100 predicts not-taken
    idle(32'h100);

    // BEQ trained three times at 0x100: 01 -> 10 -> 11
    step(1, 1, 32'h100, T_BRANCH, 1, 0, 32'h100, T_BRANCH, 3'd0, 32'd5, 32'd5, 0);
    idle(32'h100);
    step(1, 1, 32'h100, T_BRANCH, 1, 0, 32'h100, T_BRANCH, 3'd0, 32'd5, 32'd5, 0);
    idle(32'h100);
    step(1, 1, 32'h100, T_BRANCH, 1, 0, 32'h100, T_BRANCH, 3'd0, 32'd5, 32'd5, 1);
    idle(32'h100);

    // Signed vs unsigned compare with the same operands
    step(1, 1, 32'h200, T_BRANCH, 1, 0, 32'h200, T_BRANCH, 3'd4, 32'hFFFF_FFFF, 32'd1, 0);
    idle(32'h200);
    step(1, 1, 32'h200, T_BRANCH, 1, 0, 32'h200, T_BRANCH, 3'd6, 32'hFFFF_FFFF, 32'd1, 1);
    idle(32'h200);

    // JAL, then a wrong-path taken branch during the FLUSH cycle
    step(1, 0, 32'h0, T_OP, 1, 0, 32'h300, T_JAL, 3'd0, 32'd0, 32'd0, 0);
    step(1, 1, 32'h400, T_BRANCH, 1, 0, 32'h400, T_BRANCH, 3'd0, 32'd7, 32'd7, 0);
    idle(32'h400);
    step(1, 0, 32'h0, T_OP, 1, 0, 32'h304, T_JALR, 3'd0, 32'd0, 32'd0, 0);
    idle(32'h304);

    // Stalled taken BNE, then an illegal FUNC3
    step(1, 1, 32'h500, T_BRANCH, 1, 1, 32'h500, T_BRANCH, 3'd1, 32'd1, 32'd2, 0);
    step(1, 1, 32'h500, T_BRANCH, 1, 0, 32'h500, T_BRANCH, 3'd2, 32'd1, 32'd2, 0);

    // Saturation at 0x600 with decode reading the same entry each cycle
    for (int i = 0; i < 5; i++)
      step(1, 1, 32'h600, T_BRANCH, 1, 0, 32'h600, T_BRANCH, 3'd0, 32'd1, 32'd2, 0);
    step(1, 1, 32'h600, T_BRANCH, 1, 0, 32'h600, T_BRANCH, 3'd5, 32'd3, 32'd2, 0);
    idle(32'h600);
    // Aliased PC (differs above the index bits) shares the entry
    step(1, 1, 32'h1_0600, T_BRANCH, 1, 0, 32'h1_0600, T_BRANCH, 3'd7, 32'd9, 32'd2, 1);
    idle(32'h600);

    // Reset coinciding with a resolve: reset wins, no training
    step(0, 1, 32'h100, T_BRANCH, 1, 0, 32'h100, T_BRANCH, 3'd0, 32'd1, 32'd1, 0);
    idle(32'h100);

    // Randomized transactions
    for (int n = 0; n < 500; n++) begin
      rpc = ($urandom & 32'h0003_0000) | (32'($urandom_range(0, 95)) << 2);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : ~a);
      step(($urandom_range(0, 63) != 0),
           $urandom_range(0, 1),
           ($urandom & 32'h0003_0000) | (32'($urandom_range(0, 95)) << 2),
           ops[$urandom_range(0, 8)],
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 7) == 0),
           rpc,
           ops[$urandom_range(0, 8)],
           3'($urandom_range(0, 7)),
           a, b,
           $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Pipelined, parametrised successor to the combinational branch-condition logic for the pipelined OTTER.
- Keeps a BHT of 2-bit saturating counters and gives decode a taken/not-taken prediction.
- Resolves branches and jumps in EX and registers the PC-source select and flush for the next cycle.
- Trains the BHT and keeps branch and mispredict statistics counters.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, number of counters; must be a power of 2, at least 2. IDX_W = $clog2(BHT_ENTRIES).
- CTR_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset: one clock; reset is synchronous and active-low.
- DEC_VALID  in  1  decode slot holds an instruction.
- DEC_PC  in  XLEN  PC of the decode instruction.
- DEC_OPCODE  in  7  IR[6:0] in decode.
- PRED_TAKEN  out  1  prediction for the decode instruction (combinational).
- EX_VALID  in  1  EX slot holds an instruction.
- EX_STALL  in  1  EX frozen this cycle.
- EX_PC  in  XLEN  PC of the EX instruction.
- EX_OPCODE  in  7  IR[6:0] in EX.
- EX_FUNC3  in  3  IR[14:12] in EX.
- EX_RS1  in  XLEN  forwarded rs1 value.
- EX_RS2  in  XLEN  forwarded rs2 value.
- EX_PRED_TAKEN  in  1  prediction carried down the pipeline from decode.
- PCSOURCE  out  3  registered PC mux select.
- FLUSH  out  1  registered; squash IF/DEC/EX.
- BR_COUNT  out  32  resolved conditional branches.
- MISPRED_COUNT  out  32  mispredicted conditional branches.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - PCSOURCE=3'b000, FLUSH=0, BR_COUNT=0, MISPRED_COUNT=0.
  - All BHT entries = CTR_INIT.
  - Reset in the same cycle as an EX resolve wins; no update occurs.
- BHT index: PC[IDX_W+1:2]. Bits [1:0] are ignored.
- Prediction:
  - PRED_TAKEN = DEC_VALID & (DEC_OPCODE==BRANCH) & bht[idx(DEC_PC)][1]. Otherwise 0.
  - The read returns the pre-edge table value, with no bypass from a same-cycle EX update.
- Condition evaluation (XLEN-wide):
  - eq: RS1==RS2. lt: signed compare. ltu: unsigned compare.
  - FUNC3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - FUNC3 010/011 is illegal: treated as not-taken, no BHT update, not counted.
- Resolve qualifier: res = EX_VALID & ~EX_STALL & ~FLUSH.
  - The EX instruction in the cycle FLUSH is high is wrong-path and ignored.
- PCSOURCE / FLUSH at the next edge when res=1:
  - JAL: 011, FLUSH=1.
  - JALR: 001, FLUSH=1.
  - BRANCH, taken, predicted not-taken: 010 (branch target), FLUSH=1.
  - BRANCH, not-taken, predicted taken: 100 (recover EX_PC+4), FLUSH=1.
  - BRANCH, correctly predicted: 000, FLUSH=0.
  - Any other opcode: 000, FLUSH=0.
- When res=0: PCSOURCE=000 and FLUSH=0 next cycle. A stall does not hold a pending redirect; the redirect already issued.
- Latency: exactly 1 cycle from EX resolve to PCSOURCE/FLUSH. FLUSH is a single-cycle pulse.
- BHT update, on res & BRANCH & legal FUNC3 at the same edge:
  - Taken: counter increments, saturating at 11.
  - Not-taken: counter decrements, saturating at 00.
  - Only the indexed entry changes.
- Statistics:
  - BR_COUNT +1 per legal resolved BRANCH.
  - MISPRED_COUNT +1 per mispredict.
  - Both wrap modulo 2^32.
- Aliasing: PCs differing only above bit IDX_W+1 share an entry. This is intended, with no tag.

Decomposition:
- Shared package otter_pkg holds:
  - opcode_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM).
  - pcsource_t enum (PC_PLUS4=000, PC_JALR=001, PC_BRANCH=010, PC_JAL=011, PC_RECOVER=100).
  - func3 branch constants.
- Sub-module bht_2bit (parameters ENTRIES, INIT) contains:
  - Counter array, combinational read port, saturating update port, synchronous reset.
- Top level contains the compare, decision, and output/statistics registers.

Test Plan:
- Reset with RST_N=0 for 2 cycles, release -> PCSOURCE=000, FLUSH=0, both counters 0, PRED_TAKEN=0 for a BRANCH at PC 0x100.
- BEQ at PC 0x100, RS1=RS2=5, pred 0 -> next cycle PCSOURCE=010, FLUSH=1, MISPRED_COUNT=1. Repeat -> bht[0x40 mod 64] goes 01->10->11; third pass with pred 1 -> PCSOURCE=000, FLUSH=0.
- BLT RS1=0xFFFFFFFF, RS2=1 -> taken. BLTU with the same operands -> not-taken. With pred 1 -> PCSOURCE=100, FLUSH=1.
- JAL with EX_VALID=1, then a valid BRANCH in EX in the following (FLUSH) cycle -> that BRANCH is ignored: no counter change, BR_COUNT unchanged.
- EX_STALL=1 with a taken BNE -> PCSOURCE=000, no BHT update. Also FUNC3=010 -> no update, no count.
- Saturation: 5 not-taken resolves at one PC -> counter 00, stays 00. Same-cycle decode read of that index returns the pre-update value.
